sd_spi_card_model: RTL and testbench

//  SPI-mode SD card responder: the card end of the SD SPI link driven by our host controller.

---
 rtl/sd_spi_card_model_pkg.sv | 65 ++++++
 rtl/sd_spi_card_model_if.sv | 22 ++
 rtl/sd_spi_card_model_crc16.sv | 29 ++
 rtl/sd_spi_card_model.sv | 334 +++++++++++++++++++++++++++++++++
 tb/tb_sd_spi_card_model.sv | 309 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sd_spi_card_model_pkg.sv
// SD SPI card model: shared command indices, R1 bits, tokens, CRC helpers.
// Also used by the host controller side of the link.
package sd_spi_card_model_pkg;

  localparam logic [5:0] CMD_GO_IDLE   = 6'd0;
  localparam logic [5:0] CMD_SEND_OP   = 6'd1;
  localparam logic [5:0] CMD_SEND_IF   = 6'd8;
  localparam logic [5:0] CMD_RD_SINGLE = 6'd17;
  localparam logic [5:0] ACMD_SEND_OP  = 6'd41;
  localparam logic [5:0] CMD_APP       = 6'd55;

  localparam logic [7:0] R1_IDLE    = 8'h01;
  localparam logic [7:0] R1_ILLEGAL = 8'h04;
  localparam logic [7:0] R1_CRC     = 8'h08;

  localparam logic [7:0] TOKEN_START = 8'hFE;
  localparam logic [6:0] CRC7_POLY   = 7'h09;
  localparam logic [15:0] CRC16_POLY = 16'h1021;

  typedef enum logic [1:0] {
    CARD_PWR,
    CARD_IDLE,
    CARD_READY
  } card_st_e;

  typedef enum logic [2:0] {
    ST_RX,
    ST_NCR,
    ST_R1,
    ST_R7,
    ST_GAP,
    ST_TOKEN,
    ST_DATA,
    ST_CRC
  } proto_st_e;

  function automatic logic [6:0] crc7_byte(
    input logic [6:0] c,
    input logic [7:0] b
  );
    logic [6:0] r;
    logic fb;
    r = c;
    for (int i = 7; i >= 0; i--) begin
      fb = b[i] ^ r[6];
      r = {r[5:0], 1'b0} ^ (fb ? CRC7_POLY : 7'h00);
    end
    return r;
  endfunction

  function automatic logic [15:0] crc16_byte(
    input logic [15:0] c,
    input logic [7:0] b
  );
    logic [15:0] r;
    logic fb;
    r = c;
    for (int i = 7; i >= 0; i--) begin
      fb = b[i] ^ r[15];
      r = {r[14:0], 1'b0} ^ (fb ? CRC16_POLY : 16'h0000);
    end
    return r;
  endfunction

endpackage

// File: rtl/sd_spi_card_model_if.sv
// SPI link plus byte memory port between host side and card model.
// The slave modport is the card end.
interface sd_spi_card_model_if;
  logic        sclk;
  logic        mosi;
  logic        ss;
  logic        miso;
  logic [31:0] mem_addr;
  logic        mem_req;
  logic [7:0]  mem_data;
  logic        mem_valid;

  modport master (
    output sclk, mosi, ss, mem_data, mem_valid,
    input  miso, mem_addr, mem_req
  );

  modport slave (
    input  sclk, mosi, ss, mem_data, mem_valid,
    output miso, mem_addr, mem_req
  );
endinterface

// File: rtl/sd_spi_card_model_crc16.sv
// Byte-wise CRC16-CCITT accumulator for the read data block.
// Cleared at the start token, advanced once per sent data byte.
module sd_spi_card_model_crc16
  import sd_spi_card_model_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        clr,
  input  logic        en,
  input  logic [7:0]  din,
  output logic [15:0] crc
);

  logic [15:0] crc_q, crc_d;

  always_comb begin
    crc_d = crc_q;
    if (clr) crc_d = 16'h0000;
    else if (en) crc_d = crc16_byte(crc_q, din);
  end

  always_ff @(posedge clock) begin
    if (reset) crc_q <= 16'h0000;
    else crc_q <= crc_d;
  end

  assign crc = crc_q;

endmodule

// File: rtl/sd_spi_card_model.sv
// SPI-mode SD card responder: oversampled SPI, command decode,
// R1/R7 replies and single-block reads from a byte memory port.
module sd_spi_card_model
  import sd_spi_card_model_pkg::*;
#(
  parameter int NCR_BYTES  = 1,
  parameter int TOKEN_GAP  = 2,
  parameter int INIT_POLLS = 3,
  parameter int CHECK_CRC  = 1,
  parameter int BLOCK_ADDR = 1
) (
  input  logic                 clock,
  input  logic                 reset,
  sd_spi_card_model_if.slave   bus,
  output logic                 cmd_valid,
  output logic [5:0]           cmd_index,
  output logic [31:0]          cmd_arg,
  output logic                 card_ready,
  output logic                 crc_err,
  output logic                 underrun
);

  logic [2:0] sclk_s_q;
  logic [1:0] mosi_s_q;
  logic [1:0] ss_s_q;

  proto_st_e   st_q, st_d;
  card_st_e    card_q, card_d;
  logic [2:0]  bit_q, bit_d;
  logic [6:0]  rx_sh_q, rx_sh_d;
  logic [7:0]  tx_sh_q, tx_sh_d;
  logic [8:0]  cnt_q, cnt_d;
  logic [2:0]  frm_q, frm_d;
  logic [6:0]  crc7_q, crc7_d;
  logic [5:0]  idx_q, idx_d;
  logic [31:0] arg_q, arg_d;
  logic        app_q, app_d;
  logic [7:0]  polls_q, polls_d;
  logic [7:0]  resp_q, resp_d;
  logic        r7_q, r7_d;
  logic        rd_q, rd_d;
  logic [31:0] base_q, base_d;
  logic [7:0]  pref_q, pref_d;
  logic        pref_vld_q, pref_vld_d;
  logic        pend_q, pend_d;
  logic        mem_req_q, mem_req_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic        cmd_valid_q, cmd_valid_d;
  logic [5:0]  cmd_index_q, cmd_index_d;
  logic [31:0] cmd_arg_q, cmd_arg_d;
  logic        crc_err_q, crc_err_d;
  logic        underrun_q, underrun_d;

  logic        ss_hi, rise, fall, mosi_s;
  logic [7:0]  rx_byte;
  logic        idle;
  logic        crc_clr, crc_en;
  logic [7:0]  crc_din;
  logic [15:0] crc16;

  assign ss_hi  = ss_s_q[1];
  assign mosi_s = mosi_s_q[1];
  assign rise   = sclk_s_q[1] & ~sclk_s_q[2];
  assign fall   = ~sclk_s_q[1] & sclk_s_q[2];
  assign idle   = (card_q != CARD_READY);
  assign rx_byte = {rx_sh_q, mosi_s};

  sd_spi_card_model_crc16 u_crc16 (
    .clock (clock),
    .reset (reset),
    .clr   (crc_clr),
    .en    (crc_en),
    .din   (crc_din),
    .crc   (crc16)
  );

  always_comb begin
    st_d        = st_q;
    card_d      = card_q;
    bit_d       = bit_q;
    rx_sh_d     = rx_sh_q;
    tx_sh_d     = tx_sh_q;
    cnt_d       = cnt_q;
    frm_d       = frm_q;
    crc7_d      = crc7_q;
    idx_d       = idx_q;
    arg_d       = arg_q;
    app_d       = app_q;
    polls_d     = polls_q;
    resp_d      = resp_q;
    r7_d        = r7_q;
    rd_d        = rd_q;
    base_d      = base_q;
    pref_d      = pref_q;
    pref_vld_d  = pref_vld_q;
    pend_d      = pend_q;
    mem_req_d   = 1'b0;
    mem_addr_d  = mem_addr_q;
    cmd_valid_d = 1'b0;
    cmd_index_d = cmd_index_q;
    cmd_arg_d   = cmd_arg_q;
    crc_err_d   = 1'b0;
    underrun_d  = underrun_q;
    crc_clr     = 1'b0;
    crc_en      = 1'b0;
    crc_din     = 8'h00;

    if (bus.mem_valid && pend_q) begin
      pref_d     = bus.mem_data;
      pref_vld_d = 1'b1;
      pend_d     = 1'b0;
    end

    // Deselect overrides everything and drops any in-flight fetch.
    if (ss_hi) begin
      bit_d      = 3'd0;
      tx_sh_d    = 8'hFF;
      st_d       = ST_RX;
      frm_d      = 3'd0;
      pend_d     = 1'b0;
      pref_vld_d = 1'b0;
    end else if (rise) begin
      bit_d   = bit_q + 3'd1;
      rx_sh_d = {rx_sh_q[5:0], mosi_s};
      if (bit_q == 3'd7 && st_q == ST_RX) begin
        if (frm_q == 3'd0) begin
          if (rx_byte[7:6] == 2'b01) begin
            idx_d  = rx_byte[5:0];
            crc7_d = crc7_byte(7'h00, rx_byte);
            frm_d  = 3'd1;
          end
        end else if (frm_q != 3'd5) begin
          arg_d  = {arg_q[23:0], rx_byte};
          crc7_d = crc7_byte(crc7_q, rx_byte);
          frm_d  = frm_q + 3'd1;
        end else begin
          frm_d       = 3'd0;
          cmd_valid_d = 1'b1;
          cmd_index_d = idx_q;
          cmd_arg_d   = arg_q;
          st_d        = ST_NCR;
          cnt_d       = 9'd0;
          r7_d        = 1'b0;
          rd_d        = 1'b0;
          app_d       = 1'b0;
          // End bit is part of the check, so a bad stop bit also fails.
          if (CHECK_CRC != 0 && rx_byte != {crc7_q, 1'b1}) begin
            resp_d    = R1_CRC | {7'd0, idle};
            crc_err_d = 1'b1;
          end else if (idx_q == CMD_GO_IDLE) begin
            resp_d  = R1_IDLE;
            card_d  = CARD_IDLE;
            polls_d = 8'd0;
          end else if (card_q == CARD_PWR) begin
            resp_d = R1_ILLEGAL | {7'd0, idle};
          end else if (idx_q == CMD_SEND_IF) begin
            resp_d = {7'd0, idle};
            r7_d   = 1'b1;
          end else if (idx_q == CMD_APP) begin
            resp_d = {7'd0, idle};
            app_d  = 1'b1;
          end else if ((idx_q == ACMD_SEND_OP && app_q) ||
                       idx_q == CMD_SEND_OP) begin
            if (polls_q < 8'(INIT_POLLS)) begin
              resp_d  = R1_IDLE;
              polls_d = polls_q + 8'd1;
            end else begin
              resp_d = 8'h00;
              card_d = CARD_READY;
            end
          end else if (idx_q == CMD_RD_SINGLE &&
                       card_q == CARD_READY) begin
            resp_d = 8'h00;
            rd_d   = 1'b1;
            base_d = (BLOCK_ADDR != 0) ?
                     {arg_q[22:0], 9'd0} : arg_q;
          end else begin
            resp_d = R1_ILLEGAL | {7'd0, idle};
          end
        end
      end
    end else if (fall) begin
      if (bit_q != 3'd0) begin
        tx_sh_d = {tx_sh_q[6:0], 1'b1};
      end else begin
        unique case (st_q)
          ST_RX: tx_sh_d = 8'hFF;
          ST_NCR: begin
            tx_sh_d = 8'hFF;
            if (cnt_q == 9'(NCR_BYTES - 1)) begin
              st_d  = ST_R1;
              cnt_d = 9'd0;
            end else begin
              cnt_d = cnt_q + 9'd1;
            end
          end
          ST_R1: begin
            tx_sh_d = resp_q;
            cnt_d   = 9'd0;
            if (r7_q) st_d = ST_R7;
            else if (!rd_q) st_d = ST_RX;
            else if (TOKEN_GAP == 0) st_d = ST_TOKEN;
            else st_d = ST_GAP;
          end
          ST_R7: begin
            unique case (cnt_q[1:0])
              2'd2:    tx_sh_d = 8'h01;
              2'd3:    tx_sh_d = cmd_arg_q[7:0];
              default: tx_sh_d = 8'h00;
            endcase
            cnt_d = cnt_q + 9'd1;
            if (cnt_q[1:0] == 2'd3) st_d = ST_RX;
          end
          ST_GAP: begin
            tx_sh_d = 8'hFF;
            if (cnt_q == 9'(TOKEN_GAP - 1)) begin
              st_d  = ST_TOKEN;
              cnt_d = 9'd0;
            end else begin
              cnt_d = cnt_q + 9'd1;
            end
          end
          ST_TOKEN: begin
            tx_sh_d    = TOKEN_START;
            crc_clr    = 1'b1;
            mem_req_d  = 1'b1;
            mem_addr_d = base_q;
            pend_d     = 1'b1;
            pref_vld_d = 1'b0;
            st_d       = ST_DATA;
            cnt_d      = 9'd0;
          end
          ST_DATA: begin
            tx_sh_d    = pref_vld_q ? pref_q : 8'h00;
            underrun_d = underrun_q | ~pref_vld_q;
            pref_vld_d = 1'b0;
            crc_en     = 1'b1;
            crc_din    = pref_vld_q ? pref_q : 8'h00;
            if (cnt_q == 9'd511) begin
              st_d  = ST_CRC;
              cnt_d = 9'd0;
            end else begin
              mem_req_d  = 1'b1;
              mem_addr_d = base_q + {23'd0, cnt_q} + 32'd1;
              pend_d     = 1'b1;
              cnt_d      = cnt_q + 9'd1;
            end
          end
          ST_CRC: begin
            tx_sh_d = cnt_q[0] ? crc16[7:0] : crc16[15:8];
            cnt_d   = cnt_q + 9'd1;
            if (cnt_q[0]) st_d = ST_RX;
          end
          default: tx_sh_d = 8'hFF;
        endcase
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sclk_s_q    <= 3'b000;
      mosi_s_q    <= 2'b11;
      ss_s_q      <= 2'b11;
      st_q        <= ST_RX;
      card_q      <= CARD_PWR;
      bit_q       <= 3'd0;
      rx_sh_q     <= 7'd0;
      tx_sh_q     <= 8'hFF;
      cnt_q       <= 9'd0;
      frm_q       <= 3'd0;
      crc7_q      <= 7'd0;
      idx_q       <= 6'd0;
      arg_q       <= 32'd0;
      app_q       <= 1'b0;
      polls_q     <= 8'd0;
      resp_q      <= 8'hFF;
      r7_q        <= 1'b0;
      rd_q        <= 1'b0;
      base_q      <= 32'd0;
      pref_q      <= 8'd0;
      pref_vld_q  <= 1'b0;
      pend_q      <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_addr_q  <= 32'd0;
      cmd_valid_q <= 1'b0;
      cmd_index_q <= 6'd0;
      cmd_arg_q   <= 32'd0;
      crc_err_q   <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      sclk_s_q    <= {sclk_s_q[1:0], bus.sclk};
      mosi_s_q    <= {mosi_s_q[0], bus.mosi};
      ss_s_q      <= {ss_s_q[0], bus.ss};
      st_q        <= st_d;
      card_q      <= card_d;
      bit_q       <= bit_d;
      rx_sh_q     <= rx_sh_d;
      tx_sh_q     <= tx_sh_d;
      cnt_q       <= cnt_d;
      frm_q       <= frm_d;
      crc7_q      <= crc7_d;
      idx_q       <= idx_d;
      arg_q       <= arg_d;
      app_q       <= app_d;
      polls_q     <= polls_d;
      resp_q      <= resp_d;
      r7_q        <= r7_d;
      rd_q        <= rd_d;
      base_q      <= base_d;
      pref_q      <= pref_d;
      pref_vld_q  <= pref_vld_d;
      pend_q      <= pend_d;
      mem_req_q   <= mem_req_d;
      mem_addr_q  <= mem_addr_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_index_q <= cmd_index_d;
      cmd_arg_q   <= cmd_arg_d;
      crc_err_q   <= crc_err_d;
      underrun_q  <= underrun_d;
    end
  end

  assign bus.miso     = tx_sh_q[7];
  assign bus.mem_req  = mem_req_q;
  assign bus.mem_addr = mem_addr_q;
  assign cmd_valid    = cmd_valid_q;
  assign cmd_index    = cmd_index_q;
  assign cmd_arg      = cmd_arg_q;
  assign card_ready   = (card_q == CARD_READY);
  assign crc_err      = crc_err_q;
  assign underrun     = underrun_q;

endmodule

// File: tb/tb_sd_spi_card_model.sv
// Bench for sd_spi_card_model: host-side SPI driver, ramp memory,
// and a miso byte monitor checking against an expected-byte queue.
module tb_sd_spi_card_model;

  localparam int HALF = 5;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid;
  logic [5:0]  cmd_index;
  logic [31:0] cmd_arg;
  logic        card_ready;
  logic        crc_err;
  logic        underrun;

  always #5 clock = ~clock;

  sd_spi_card_model_if bus ();

  sd_spi_card_model #(
    .NCR_BYTES  (1),
    .TOKEN_GAP  (2),
    .INIT_POLLS (3),
    .CHECK_CRC  (1),
    .BLOCK_ADDR (1)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .bus        (bus.slave),
    .cmd_valid  (cmd_valid),
    .cmd_index  (cmd_index),
    .cmd_arg    (cmd_arg),
    .card_ready (card_ready),
    .crc_err    (crc_err),
    .underrun   (underrun)
  );

  int total = 0;
  int bad = 0;
  int n_cmd_valid = 0;
  int n_crc_err = 0;
  int lat = 2;
  bit chk_on = 1'b0;

  logic [7:0]  exp_q[$];
  string       name_q[$];
  logic [31:0] mq_addr[$];
  longint      mq_due[$];
  longint      cyc = 0;

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  always @(posedge clock) begin
    if (cmd_valid) n_cmd_valid++;
    if (crc_err) n_crc_err++;
  end

  // Ramp memory: byte at address a is a[7:0], returned after lat clocks.
  initial begin
    bus.mem_valid = 1'b0;
    bus.mem_data  = 8'h00;
    forever begin
      @(negedge clock);
      cyc++;
      bus.mem_valid = 1'b0;
      if (bus.mem_req) begin
        mq_addr.push_back(bus.mem_addr);
        mq_due.push_back(cyc + lat);
      end
      if (mq_due.size() > 0 && cyc >= mq_due[0]) begin
        bus.mem_valid = 1'b1;
        bus.mem_data  = mq_addr[0][7:0];
        void'(mq_addr.pop_front());
        void'(mq_due.pop_front());
      end
    end
  end

  // Monitor: assemble miso bytes, compare the ones flagged for checking.
  initial begin
    int nb;
    logic [7:0] sh;
    logic [7:0] e;
    string nm;
    nb = 0;
    sh = 8'h00;
    forever begin
      @(posedge bus.sclk or posedge bus.ss);
      if (bus.ss) begin
        nb = 0;
      end else begin
        sh = {sh[6:0], bus.miso};
        nb++;
        if (nb == 8) begin
          nb = 0;
          if (chk_on) begin
            if (exp_q.size() == 0) begin
              total++;
              bad++;
              $display("FAIL queue underflow: got %h want none", sh);
            end else begin
              e  = exp_q.pop_front();
              nm = name_q.pop_front();
              check(nm, {24'd0, sh}, {24'd0, e});
            end
          end
        end
      end
    end
  end

  function automatic logic [7:0] tb_crc7(input logic [5:0] idx,
                                         input logic [31:0] arg);
    logic [39:0] m;
    logic [6:0] c;
    logic fb;
    m = {2'b01, idx, arg};
    c = 7'd0;
    for (int i = 39; i >= 0; i--) begin
      fb = m[i] ^ c[6];
      c = {c[5:0], 1'b0};
      if (fb) c = c ^ 7'h09;
    end
    return {c, 1'b1};
  endfunction

  function automatic logic [15:0] tb_crc16_block();
    logic [15:0] c;
    logic [7:0] b;
    logic fb;
    c = 16'h0000;
    for (int n = 0; n < 512; n++) begin
      b = n[7:0];
      for (int i = 7; i >= 0; i--) begin
        fb = b[i] ^ c[15];
        c = {c[14:0], 1'b0};
        if (fb) c = c ^ 16'h1021;
      end
    end
    return c;
  endfunction

  task automatic spi_byte(input logic [7:0] tx);
    for (int i = 7; i >= 0; i--) begin
      @(negedge clock);
      bus.sclk = 1'b0;
      bus.mosi = tx[i];
      repeat (HALF) @(negedge clock);
      bus.sclk = 1'b1;
      repeat (HALF - 1) @(negedge clock);
    end
  endtask

  task automatic sel();
    @(negedge clock);
    bus.ss = 1'b0;
    repeat (4) @(negedge clock);
  endtask

  task automatic desel();
    @(negedge clock);
    bus.sclk = 1'b0;
    bus.mosi = 1'b1;
    repeat (HALF) @(negedge clock);
    bus.ss = 1'b1;
    repeat (6) @(negedge clock);
  endtask

  task automatic expect_byte(input logic [7:0] e, input string nm);
    exp_q.push_back(e);
    name_q.push_back(nm);
    chk_on = 1'b1;
    spi_byte(8'hFF);
    chk_on = 1'b0;
  endtask

  task automatic send_cmd(input logic [5:0] idx, input logic [31:0] arg,
                          input logic [7:0] crc);
    spi_byte({2'b01, idx});
    spi_byte(arg[31:24]);
    spi_byte(arg[23:16]);
    spi_byte(arg[15:8]);
    spi_byte(arg[7:0]);
    spi_byte(crc);
  endtask

  task automatic cmd_r1(input logic [5:0] idx, input logic [31:0] arg,
                        input logic [7:0] crc, input logic [7:0] r1,
                        input string nm);
    sel();
    send_cmd(idx, arg, crc);
    expect_byte(8'hFF, "ncr fill");
    expect_byte(r1, nm);
  endtask

  task automatic read_head();
    sel();
    send_cmd(6'd17, 32'd2, tb_crc7(6'd17, 32'd2));
    expect_byte(8'hFF, "cmd17 ncr");
    expect_byte(8'h00, "cmd17 r1");
    expect_byte(8'hFF, "gap 0");
    expect_byte(8'hFF, "gap 1");
    expect_byte(8'hFE, "start token");
  endtask

  task automatic check_reset_state();
    check("miso idle", {31'd0, bus.miso}, 32'd1);
    check("card_ready reset", {31'd0, card_ready}, 32'd0);
    check("underrun reset", {31'd0, underrun}, 32'd0);
    check("cmd_index reset", {26'd0, cmd_index}, 32'd0);
    check("cmd_arg reset", cmd_arg, 32'd0);
  endtask

  initial begin
    logic [15:0] c16;
    logic [7:0] r;
    bus.sclk = 1'b0;
    bus.mosi = 1'b1;
    bus.ss   = 1'b1;
    reset    = 1'b1;
    repeat (4) @(negedge clock);
    reset = 1'b0;
    repeat (4) @(negedge clock);
    check_reset_state();

    cmd_r1(6'd0, 32'd0, 8'h95, 8'h01, "cmd0 r1");
    desel();
    check("cmd_valid pulses", n_cmd_valid, 32'd1);
    check("cmd0 index", {26'd0, cmd_index}, 32'd0);

    cmd_r1(6'd8, 32'h000001AA, 8'h87, 8'h01, "cmd8 r1");
    expect_byte(8'h00, "r7 b1");
    expect_byte(8'h00, "r7 b2");
    expect_byte(8'h01, "r7 b3");
    expect_byte(8'hAA, "r7 b4");
    desel();
    check("cmd8 arg", cmd_arg, 32'h000001AA);

    cmd_r1(6'd8, 32'h000001AA, 8'h86, 8'h09, "cmd8 bad crc r1");
    desel();
    check("crc_err pulses", n_crc_err, 32'd1);

    for (int k = 0; k < 4; k++) begin
      r = (k < 3) ? 8'h01 : 8'h00;
      cmd_r1(6'd55, 32'd0, tb_crc7(6'd55, 32'd0), 8'h01, "cmd55 r1");
      desel();
      cmd_r1(6'd41, 32'h40000000, tb_crc7(6'd41, 32'h40000000), r,
             "acmd41 r1");
      desel();
    end
    check("card_ready", {31'd0, card_ready}, 32'd1);

    c16 = tb_crc16_block();
    read_head();
    for (int i = 0; i < 512; i++) expect_byte(i[7:0], "block data");
    expect_byte(c16[15:8], "crc16 hi");
    expect_byte(c16[7:0], "crc16 lo");
    expect_byte(8'hFF, "idle after crc");
    desel();
    check("cmd17 index", {26'd0, cmd_index}, 32'd17);
    check("cmd17 arg", cmd_arg, 32'd2);

    read_head();
    for (int i = 0; i < 100; i++) expect_byte(i[7:0], "data pre-abort");
    desel();
    check("miso after abort", {31'd0, bus.miso}, 32'd1);

    read_head();
    expect_byte(8'h00, "data 0 re-read");
    expect_byte(8'h01, "data 1 re-read");
    desel();
    check("underrun clear", {31'd0, underrun}, 32'd0);

    lat = 390;
    read_head();
    for (int i = 0; i < 4; i++) expect_byte(8'h00, "underrun data");
    desel();
    check("underrun sticky", {31'd0, underrun}, 32'd1);

    @(negedge clock);
    reset = 1'b1;
    mq_addr.delete();
    mq_due.delete();
    lat = 2;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    repeat (3) @(negedge clock);
    check_reset_state();

    cmd_r1(6'd55, 32'd0, tb_crc7(6'd55, 32'd0), 8'h05, "pwr illegal");
    desel();
    cmd_r1(6'd0, 32'd0, 8'h95, 8'h01, "cmd0 after reset");
    desel();
    cmd_r1(6'd17, 32'd2, tb_crc7(6'd17, 32'd2), 8'h05, "cmd17 in idle");
    desel();

    check("queue drained", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
